window_line_buffer: RTL and testbench
=====================================

Name: window_line_buffer

Overview:
Streaming KxK sliding-window generator for the image-filter datapath.
- Accepts pre-padded pixels in raster order over a valid/ready handshake.
- Stores K-1 previous rows in line buffers.
- Emits each complete KxK window, together with its output coordinate, to the filter core.
- Parametrised successor of the fixed 3x3 memory-array window reader. No full-frame storage is required.

Parameters:
PIX_W, 8, bits per pixel
K, 3, window size; odd, >=3
IMG_W, 258, padded image width in pixels; >=K
IMG_H, 258, padded image height in pixels; >=K

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-low reset
clr  input  1  synchronous frame abort; restarts at pixel (0,0)
in_valid  input  1  in_pixel is valid
in_ready  output  1  block can accept a pixel
in_pixel  input  PIX_W  padded input pixel, raster order
out_valid  output  1  win_out is valid
out_ready  input  1  consumer accepts the window
win_out  output  K*K*PIX_W  window; element (r,c) at [(r*K+c)*PIX_W +: PIX_W]; r=0 is the top (oldest) row, c=0 is the leftmost column
out_row  output  $clog2(IMG_H)  output-image row, equal to padded row - (K-1)
out_col  output  $clog2(IMG_W)  output-image column, equal to padded col - (K-1)
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst=0), asynchronous:
  - col/row counters = 0, out_valid = 0, win_out = 0, out_row = 0, out_col = 0, frame_done = 0.
  - Line-buffer contents are don't-care.
- Handshake:
  - in_ready = !clr && (!out_valid || out_ready).
  - A pixel is accepted when in_valid && in_ready.
  - Output register is single-entry. While out_valid=1 and out_ready=0, win_out/out_row/out_col are held stable and in_ready=0.
- On accepting pixel at padded (r,c):
  - Window shift register shifts one column left.
  - New rightmost column = {linebuf[K-2][c], ..., linebuf[0][c], in_pixel}, top to bottom.
  - linebuf[i] receives the old linebuf[i-1][c]; linebuf[0][c] receives in_pixel. Line buffers are read-first.
- Window emission:
  - If r >= K-1 and c >= K-1: next edge sets out_valid=1 and loads the window covering rows r-K+1..r, cols c-K+1..c; out_row = r-K+1, out_col = c-K+1.
  - Latency is 1 cycle from acceptance to out_valid.
  - Otherwise out_valid clears on the next edge if out_ready=1 (or if out_valid was already 0).
- Counters:
  - c increments per accepted pixel and wraps at IMG_W-1 to 0, incrementing r.
  - After (IMG_H-1, IMG_W-1) is accepted, r and c both wrap to 0 and frame_done pulses on the next cycle.
  - Back-to-back frames need no idle cycle.
- No stale windows: columns c < K-1 never emit, so window-register contents from the previous row or frame never appear on win_out.
- clr=1:
  - Next edge: counters = 0, out_valid = 0, frame_done = 0; any pending window is dropped.
  - in_ready=0 during clr, so a pixel presented that cycle is not accepted.
- Windows per frame: (IMG_W-K+1)*(IMG_H-K+1).
- Simulation-time checks flag a fatal error for K even, K<3, IMG_W<K, or IMG_H<K.

Optional Feature:
WLB_FRAME_FLAGS_EN
- Defined: adds outputs out_sof and out_eof, each 1 bit, registered with win_out and held under backpressure.
  - out_sof=1 on the window with out_row=0, out_col=0.
  - out_eof=1 on the window with out_row=IMG_H-K, out_col=IMG_W-K.
  - Both reset to 0.
- Undefined: these ports do not exist; all other behaviour is identical.

Decomposition:
- Package window_pkg: default PIX_W/K/IMG_W/IMG_H constants, the window-element index function (r*K+c), and the coordinate-width functions.
- One sub-module, line_buffer_ram: simple dual-port, read-first, depth IMG_W, width PIX_W, shared address. Instantiated K-1 times.

Test Plan:
- Config for tests 1-5: IMG_W=8, IMG_H=6, K=3, PIX_W=8, pixel value = r*16+c.
1. rst asserted mid-stream -> immediately out_valid=0, win_out=0, frame_done=0; after release, in_ready=1.
2. Full frame, out_ready=1 -> first out_valid one cycle after accepting (2,2) with win_out elements 00,01,02,10,11,12,20,21,22 and out_row=0, out_col=0. Exactly 24 windows. Last window has element 8 = 0x57, out_row=3, out_col=5.
3. out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, win_out held. After release, the window sequence has no loss and no duplicates.
4. Two back-to-back frames -> frame_done pulses once per frame, one cycle after accepting (5,7). Second frame's first window appears only after its (2,2), with values 00..22.
5. clr asserted after accepting (3,4) -> out_valid=0 next cycle. The next frame streamed from (0,0) gives exactly 24 correct windows.
6. K=5, IMG_W=8, IMG_H=6 -> first window after accepting (4,4) with element 0 = 0x00 and element 24 = 0x44. Exactly 8 windows. With WLB_FRAME_FLAGS_EN, out_sof is set on the first window and out_eof on the eighth.

Source files
------------

// File: rtl/window_pkg.sv
// Shared constants and helpers for the KxK sliding-window line buffer.
package window_pkg;

    localparam int WLB_PIX_W = 8;
    localparam int WLB_K     = 3;
    localparam int WLB_IMG_W = 258;
    localparam int WLB_IMG_H = 258;

    // Flat element index of window entry (r,c); r=0 is the oldest row.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // Width of a coordinate counter that spans 0..n-1.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of storage: simple dual-port, read-first, shared address.
// Read is combinational so the previous row's pixel is available in the
// same cycle the new pixel overwrites it.
module line_buffer_ram
    import window_pkg::*;
#(
    parameter int DEPTH = WLB_IMG_W,
    parameter int WIDTH = WLB_PIX_W
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [coord_w(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]          i_wdata,
    output logic [WIDTH-1:0]          o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Write the incoming row pixel; old contents were already read out.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/window_line_buffer.sv
// Streaming KxK window generator over pre-padded raster pixels.
// Optional macro WLB_FRAME_FLAGS_EN adds out_sof/out_eof window flags.
module window_line_buffer
    import window_pkg::*;
#(
    parameter int PIX_W = WLB_PIX_W,
    parameter int K     = WLB_K,
    parameter int IMG_W = WLB_IMG_W,
    parameter int IMG_H = WLB_IMG_H
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*K*PIX_W-1:0]     win_out,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
`ifdef WLB_FRAME_FLAGS_EN
    output logic                     out_sof,
    output logic                     out_eof,
`endif
    output logic                     frame_done
);

    localparam int RW = coord_w(IMG_H);
    localparam int CW = coord_w(IMG_W);
    localparam int NL = K - 1;
    localparam int WW = K * K * PIX_W;
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);

    // Illegal geometry stops simulation on the first clock.
    if ((K % 2) == 0 || K < 3 || IMG_W < K || IMG_H < K) begin : g_bad_params
        always @(posedge clk) $fatal(1, "window_line_buffer: illegal K/IMG_W/IMG_H");
    end

    logic [RW-1:0]             r_row;
    logic [CW-1:0]             r_col;
    logic [NL-1:0][PIX_W-1:0]  w_lb_wdata;
    logic [NL-1:0][PIX_W-1:0]  w_lb_rdata;
    logic [K-1:0][PIX_W-1:0]   w_newcol;
    logic [WW-1:0]             r_win;
    logic [WW-1:0]             w_win_next;
    logic [WW-1:0]             r_win_out;
    logic                      r_out_valid;
    logic                      r_frame_done;
    logic [RW-1:0]             r_out_row;
    logic [CW-1:0]             r_out_col;
    logic                      w_accept;
    logic                      w_emit;
    logic                      w_last_col;
    logic                      w_last_pix;
`ifdef WLB_FRAME_FLAGS_EN
    logic                      r_sof;
    logic                      r_eof;
`endif

    // Single-entry output: a held window blocks intake until consumed.
    assign in_ready   = !clr && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_pix = w_last_col && (r_row == ROW_LAST);
    // Left columns of a row would mix in the previous row's pixels.
    assign w_emit     = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);

    // Rows cascade: each buffer passes its old pixel down to the next.
    assign w_lb_wdata[0] = in_pixel;
    for (genvar i = 1; i < NL; i++) begin : g_chain
        assign w_lb_wdata[i] = w_lb_rdata[i-1];
    end

    for (genvar i = 0; i < NL; i++) begin : g_lb
        line_buffer_ram #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_lb (
            .clk     (clk),
            .i_we    (w_accept),
            .i_addr  (r_col),
            .i_wdata (w_lb_wdata[i]),
            .o_rdata (w_lb_rdata[i])
        );
    end

    // New rightmost column, top (oldest buffer) to bottom (live pixel).
    for (genvar r = 0; r < NL; r++) begin : g_newcol
        assign w_newcol[r] = w_lb_rdata[NL-1-r];
    end
    assign w_newcol[K-1] = in_pixel;

    // Window after shifting one column left and appending the new column.
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_win_next[win_idx(r, c, K)*PIX_W +: PIX_W] =
                    r_win[win_idx(r, c + 1, K)*PIX_W +: PIX_W];
            end
            w_win_next[win_idx(r, K - 1, K)*PIX_W +: PIX_W] = w_newcol[r];
        end
    end

    // Window shift register advances on every accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_win <= '0;
        else if (w_accept) r_win <= w_win_next;
    end

    // Raster position of the next pixel; clr restarts at (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Output register: load on a complete window, hold under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_win_out    <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
`ifdef WLB_FRAME_FLAGS_EN
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
`endif
        end else if (clr) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last_pix;
            if (w_accept && w_emit) begin
                r_out_valid <= 1'b1;
                r_win_out   <= w_win_next;
                r_out_row   <= r_row - ROW_FIRST;
                r_out_col   <= r_col - COL_FIRST;
`ifdef WLB_FRAME_FLAGS_EN
                r_sof       <= (r_row == ROW_FIRST) && (r_col == COL_FIRST);
                r_eof       <= w_last_pix;
`endif
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign win_out    = r_win_out;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;
`ifdef WLB_FRAME_FLAGS_EN
    assign out_sof    = r_sof;
    assign out_eof    = r_eof;
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer (K=3 main DUT, K=5 side DUT).
module tb_window_line_buffer;

    localparam int PW    = 8;
    localparam int K     = 3;
    localparam int K5    = 5;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int NWIN  = (W - K + 1) * (H - K + 1);
    localparam int NWIN5 = (W - K5 + 1) * (H - K5 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, clr, in_valid, in_ready, out_valid, out_ready, frame_done;
    logic [PW-1:0]       in_pixel;
    logic [K*K*PW-1:0]   win_out;
    logic [2:0]          out_row, out_col;
    logic                clr5, in_valid5, in_ready5, out_valid5, out_ready5, frame_done5;
    logic [PW-1:0]       in_pixel5;
    logic [K5*K5*PW-1:0] win_out5;
    logic [2:0]          out_row5, out_col5;
`ifdef WLB_FRAME_FLAGS_EN
    logic out_sof, out_eof, out_sof5, out_eof5;
`endif

    window_line_buffer #(.PIX_W(PW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .win_out(win_out), .out_row(out_row), .out_col(out_col),
`ifdef WLB_FRAME_FLAGS_EN
        .out_sof(out_sof), .out_eof(out_eof),
`endif
        .frame_done(frame_done)
    );

    window_line_buffer #(.PIX_W(PW), .K(K5), .IMG_W(W), .IMG_H(H)) dut5 (
        .clk(clk), .rst(rst), .clr(clr5), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_pixel(in_pixel5), .out_valid(out_valid5), .out_ready(out_ready5),
        .win_out(win_out5), .out_row(out_row5), .out_col(out_col5),
`ifdef WLB_FRAME_FLAGS_EN
        .out_sof(out_sof5), .out_eof(out_eof5),
`endif
        .frame_done(frame_done5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (K=3) ----------------
    typedef struct {
        logic [K*K*PW-1:0] win;
        int                row;
        int                col;
        bit                sof;
        bit                eof;
    } exp_t;

    exp_t sb[$];
    exp_t fe, me;
    int   img [H][W];
    int   m_r, m_c;
    bit   exp_valid_next, exp_done_next, exp_clr_next;
    int   done_cnt, win_cnt;
    logic [K*K*PW-1:0] first_win, last_win, sec_first, held;
    int   last_row, last_col;

    // Feeder: observe each handshake, update the image model, push windows.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_r = 0; m_c = 0;
            exp_valid_next = 0; exp_done_next = 0; exp_clr_next = 0;
        end else begin
            if (exp_valid_next) chk("latency_out_valid", out_valid, 1'b1);
            if (exp_clr_next)   chk("clr_drops_valid", out_valid, 1'b0);
            chk("frame_done", frame_done, exp_done_next);
            chk("in_ready", in_ready, !clr && (!out_valid || out_ready));
            if (frame_done) done_cnt++;
            exp_valid_next = 0; exp_done_next = 0; exp_clr_next = 0;
            if (clr) begin
                sb.delete();
                m_r = 0; m_c = 0;
                exp_clr_next = 1;
            end else if (in_valid && in_ready) begin
                img[m_r][m_c] = int'(in_pixel);
                if (m_r >= K - 1 && m_c >= K - 1) begin
                    fe.win = '0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            fe.win[(i*K+j)*PW +: PW] = PW'(img[m_r-K+1+i][m_c-K+1+j]);
                    fe.row = m_r - (K - 1);
                    fe.col = m_c - (K - 1);
                    fe.sof = (fe.row == 0) && (fe.col == 0);
                    fe.eof = (fe.row == H - K) && (fe.col == W - K);
                    sb.push_back(fe);
                    exp_valid_next = 1;
                end
                if (m_r == H - 1 && m_c == W - 1) exp_done_next = 1;
                if (m_c == W - 1) begin
                    m_c = 0;
                    m_r = (m_r == H - 1) ? 0 : m_r + 1;
                end else begin
                    m_c++;
                end
            end
        end
    end

    // Monitor: compare each consumed window, check hold under backpressure.
    bit held_pending;
    logic [K*K*PW-1:0] held_win;
    int held_row, held_col;
    always @(negedge clk) begin
        if (!rst) begin
            held_pending = 0;
        end else begin
            if (held_pending) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_win", win_out, held_win);
                chk("hold_row", out_row, held_row);
                chk("hold_col", out_col, held_col);
            end
            held_pending = 0;
            if (out_valid && !clr) begin
                if (!out_ready) begin
                    held_pending = 1;
                    held_win = win_out;
                    held_row = int'(out_row);
                    held_col = int'(out_col);
                end else if (sb.size() == 0) begin
                    chk("unexpected_window", out_valid, 1'b0);
                end else begin
                    me = sb.pop_front();
                    chk("win_out", win_out, me.win);
                    chk("out_row", out_row, me.row);
                    chk("out_col", out_col, me.col);
`ifdef WLB_FRAME_FLAGS_EN
                    chk("out_sof", out_sof, me.sof);
                    chk("out_eof", out_eof, me.eof);
`endif
                    if (win_cnt == 0)    first_win = win_out;
                    if (win_cnt == NWIN) sec_first = win_out;
                    last_win = win_out;
                    last_row = int'(out_row);
                    last_col = int'(out_col);
                    win_cnt++;
                end
            end
        end
    end

    // K=5 monitor: windows arrive in raster order of output coordinates.
    int w5_cnt, done5_cnt;
    always @(negedge clk) begin
        if (rst && out_valid5) begin
            chk("k5_row", out_row5, w5_cnt / (W - K5 + 1));
            chk("k5_col", out_col5, w5_cnt % (W - K5 + 1));
            for (int i = 0; i < K5; i++)
                for (int j = 0; j < K5; j++)
                    chk("k5_elem", win_out5[(i*K5+j)*PW +: PW],
                        (w5_cnt / (W-K5+1) + i) * 16 + (w5_cnt % (W-K5+1) + j));
`ifdef WLB_FRAME_FLAGS_EN
            chk("k5_sof", out_sof5, w5_cnt == 0);
            chk("k5_eof", out_eof5, w5_cnt == NWIN5 - 1);
`endif
            w5_cnt++;
        end
        if (rst && frame_done5) done5_cnt++;
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = test controls it.
    int rdy_mode;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_pix(input logic [PW-1:0] p, input int gap);
        int budget;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_pixel = p;
        budget   = 0;
        @(negedge clk);
        while (!in_ready) begin
            budget++;
            if (budget > 2000) begin
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", budget);
                n_fail++;
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "stalled");
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit rnd, input int gapmax);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(rnd ? PW'($urandom) : PW'(r * 16 + c),
                         (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
    endtask

    task automatic drain();
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    int n;
    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        clr5 = 1'b0; in_valid5 = 1'b0; in_pixel5 = '0; out_ready5 = 1'b1;
        rdy_mode = 0; done_cnt = 0; win_cnt = 0; w5_cnt = 0; done5_cnt = 0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_win_out", win_out, '0);
        chk("rst_out_row", out_row, '0);
        chk("rst_out_col", out_col, '0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_k5_win_out", win_out5, '0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: asynchronous reset mid-stream
        for (int i = 0; i < 30; i++) send_pix(PW'((i / W) * 16 + (i % W)), 0);
        chk("t1_pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_out_valid", out_valid, 1'b0);
        chk("t1_rst_win_out", win_out, '0);
        chk("t1_rst_frame_done", frame_done, 1'b0);
        chk("t1_rst_out_row", out_row, '0);
        chk("t1_rst_out_col", out_col, '0);
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("t1_in_ready_after_rst", in_ready, 1'b1);

        // 2: full pattern frame, always ready
        win_cnt = 0;
        send_frame(0, 0);
        drain();
        chk("t2_count", win_cnt, NWIN);
        for (int i = 0; i < K * K; i++)
            chk("t2_first_elem", first_win[i*PW +: PW], (i / K) * 16 + (i % K));
        chk("t2_last_elem8", last_win[8*PW +: PW], 8'h57);
        chk("t2_last_row", last_row, 3);
        chk("t2_last_col", last_col, 5);

        // 3: backpressure hold
        win_cnt = 0;
        rdy_mode = 2;
        fork
            send_frame(0, 0);
            begin
                out_ready = 1'b0;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 500) begin n++; @(negedge clk); end
                chk("t3_stall_reached", out_valid, 1'b1);
                held = win_out;
                repeat (5) begin
                    chk("t3_in_ready_low", in_ready, 1'b0);
                    chk("t3_win_held", win_out, held);
                    @(negedge clk);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                rdy_mode = 1;
            end
        join
        drain();
        chk("t3_count", win_cnt, NWIN);
        chk("t3_sb_empty", sb.size(), 0);

        // 4: back-to-back frames
        win_cnt = 0; done_cnt = 0;
        send_frame(0, 0);
        send_frame(0, 0);
        drain();
        chk("t4_done_pulses", done_cnt, 2);
        chk("t4_count", win_cnt, 2 * NWIN);
        for (int i = 0; i < K * K; i++)
            chk("t4_second_first_elem", sec_first[i*PW +: PW], (i / K) * 16 + (i % K));

        // random pixels, random gaps, random backpressure
        win_cnt = 0; done_cnt = 0;
        rdy_mode = 1;
        send_frame(1, 2);
        send_frame(1, 2);
        drain();
        chk("rand_count", win_cnt, 2 * NWIN);
        chk("rand_done_pulses", done_cnt, 2);

        // 5: clr after accepting (3,4)
        for (int i = 0; i <= 3 * W + 4; i++) send_pix(PW'((i / W) * 16 + (i % W)), 0);
        clr = 1'b1; in_valid = 1'b1; in_pixel = 8'hAA;
        @(negedge clk);
        chk("t5_in_ready_clr", in_ready, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("t5_out_valid_cleared", out_valid, 1'b0);
        win_cnt = 0;
        send_frame(0, 0);
        drain();
        chk("t5_count", win_cnt, NWIN);

        // 6: K=5 instance
        for (int i = 0; i < W * H; i++) begin
            in_valid5 = 1'b1;
            in_pixel5 = PW'((i / W) * 16 + (i % W));
            @(negedge clk);
            chk("t6_in_ready", in_ready5, 1'b1);
            @(posedge clk); #1;
            in_valid5 = 1'b0;
            if (i == 4 * W + 3) chk("t6_no_early_window", w5_cnt, 0);
            if (i == 4 * W + 4) begin
                chk("t6_first_valid", out_valid5, 1'b1);
                chk("t6_elem0", win_out5[0 +: PW], 8'h00);
                chk("t6_elem24", win_out5[24*PW +: PW], 8'h44);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t6_count", w5_cnt, NWIN5);
        chk("t6_done_pulses", done5_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
